mips_fetch_control: RTL and testbench
=====================================

Name: mips_fetch_control

Overview:
- Sequencer that sits between the instruction ROM and the execute/ALU stage of the MIPS core.
- Drives the ROM address (PC) and the 3-bit phase code (enable_fsm). The ROM latches rom[address] on the falling clock edge only while the phase is 3'b000.
- Captures the returned word, decodes R-type fields, and hands one ALU operation per instruction downstream over a valid/ready handshake.
- Retires the instruction with a single-cycle register-write strobe.

Parameters:
- ADDR_W, 5, ROM address / PC width.
- DATA_W, 32, instruction width.
- PROG_LEN, 32, number of ROM words; PC at PROG_LEN-1 is the last executable slot.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  launch/relaunch program; honoured only in IDLE or HALT.
- rom_data  in  DATA_W  instruction word from ROM, valid at the rising edge that ends FETCH.
- op_ready  in  1  execute stage accepts the operation.
- rom_address  out  ADDR_W  current PC.
- enable_fsm  out  3  phase code: 000 FETCH, 001 DECODE, 010 EXECUTE, 011 WRITEBACK, 100 HALT, 111 IDLE.
- op_valid  out  1  decoded operation is presented.
- alu_op  out  2  00 add, 01 sub, 10 mul.
- rs, rt, rd  out  5 each  register fields, bits [25:21], [20:16], [15:11].
- reg_write  out  1  one-cycle write strobe for rd.
- halt  out  1  program finished or stopped.
- illegal  out  1  sticky; set when HALT was caused by an undecodable word.

Behaviour:
- Reset, asynchronous: state IDLE, enable_fsm=111, pc=0, ir=0, op_valid=0, alu_op=00, rs=rt=rd=0, reg_write=0, halt=0, illegal=0.
- Reset mid-operation aborts immediately. op_valid drops in the same instant; no handshake completes.
- IDLE: enable_fsm=111 so the ROM holds its output. start=1 -> FETCH.
- FETCH (1 cycle): enable_fsm=000, rom_address=pc. The ROM updates on the mid-cycle falling edge. At the next rising edge, ir<=rom_data and state -> DECODE.
- DECODE (1 cycle): enable_fsm=001. Register rs/rt/rd from ir. Decode:
  - ir == 32'h0: end of program -> HALT, illegal=0.
  - opcode ir[31:26]==0 and funct 100000: alu_op=00 -> EXECUTE.
  - funct 100010: alu_op=01 -> EXECUTE.
  - funct 100110: alu_op=10 -> EXECUTE (this funct is the team's mul encoding).
  - Any other word: illegal=1 -> HALT.
- EXECUTE: enable_fsm=010, op_valid=1. alu_op/rs/rt/rd are held stable while op_valid=1 and op_ready=0. Stall is unbounded. On the edge where op_valid&&op_ready: op_valid<=0, state -> WRITEBACK.
- WRITEBACK (1 cycle): enable_fsm=011, reg_write=1 for exactly this cycle.
  - pc == PROG_LEN-1: -> HALT with pc unchanged (no wrap).
  - Otherwise pc<=pc+1 -> FETCH.
- HALT: enable_fsm=100, halt=1, op_valid=0, reg_write=0. Outputs rs/rt/rd/alu_op retain their last values.
  - start=1 clears pc, halt and illegal on that edge -> FETCH.
- start is ignored in FETCH/DECODE/EXECUTE/WRITEBACK.
- Throughput with op_ready tied high: 4 cycles per instruction (F, D, E, W).
- First FETCH begins the cycle after start is sampled.
- enable_fsm and all outputs are registered (Moore); no combinational path from inputs to outputs.

Decomposition:
- Shared package mips_pkg:
  - phase/state encodings (FETCH..IDLE, 3 bits);
  - funct constants FUNCT_ADD=6'b100000, FUNCT_SUB=6'b100010, FUNCT_MUL=6'b100110;
  - ALU_OP codes; field bit positions.
- One natural sub-module: mips_instr_decode, purely combinational. Input: ir. Outputs: rs, rt, rd, alu_op, is_end, is_illegal. The FSM registers its outputs in DECODE.

Test Plan:
- ROM {0:add,1:sub,2:mul,3:0}, op_ready=1, start pulse:
  - alu_op sequence 00,01,10 with rs=1, rt=2, rd=0;
  - reg_write pulses exactly 3 times, 4 cycles apart;
  - halt=1, illegal=0, rom_address=3.
- op_ready held 0 for 5 cycles in first EXECUTE: op_valid stays 1, alu_op/rs/rt/rd unchanged for all 5 cycles; WRITEBACK follows the cycle after op_ready rises.
- ROM[1]=32'h00220021 (funct 100001): after first instruction retires, halt=1, illegal=1, no second reg_write.
- Assert reset while in EXECUTE with op_valid=1: op_valid, halt, pc, enable_fsm go 0/0/0/111 without waiting for a clock edge; after release, start restarts at pc=0.
- PROG_LEN=4, ROM 0..3 all add: exactly 4 reg_write pulses, then HALT with rom_address=3 (no wrap to 0).
- start pulsed during DECODE ignored; start in HALT relaunches: pc=0, illegal cleared, FETCH on next cycle with enable_fsm=000.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS fetch/decode sequencer: phase codes, ALU op codes,
// R-type funct values and instruction field positions.
package mips_pkg;

   typedef enum logic [2:0] {
      ST_FETCH     = 3'b000,
      ST_DECODE    = 3'b001,
      ST_EXECUTE   = 3'b010,
      ST_WRITEBACK = 3'b011,
      ST_HALT      = 3'b100,
      ST_IDLE      = 3'b111
   } state_e;

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,
      ALU_SUB = 2'b01,
      ALU_MUL = 2'b10
   } alu_op_e;

   localparam logic [5:0] OPCODE_RTYPE = 6'b000000;
   localparam logic [5:0] FUNCT_ADD    = 6'b100000;
   localparam logic [5:0] FUNCT_SUB    = 6'b100010;
   localparam logic [5:0] FUNCT_MUL    = 6'b100110;

   localparam int OPCODE_HI = 31;
   localparam int OPCODE_LO = 26;
   localparam int RS_HI     = 25;
   localparam int RS_LO     = 21;
   localparam int RT_HI     = 20;
   localparam int RT_LO     = 16;
   localparam int RD_HI     = 15;
   localparam int RD_LO     = 11;
   localparam int FUNCT_HI  = 5;
   localparam int FUNCT_LO  = 0;

endpackage

// File: rtl/mips_instr_decode.sv
// Combinational R-type decoder: splits out register fields and classifies the word
// as add/sub/mul, end-of-program (all zero) or illegal.
module mips_instr_decode
   import mips_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] ir,
   output logic [4:0]        rs,
   output logic [4:0]        rt,
   output logic [4:0]        rd,
   output logic [1:0]        alu_op,
   output logic              is_end,
   output logic              is_illegal
);

   logic [5:0] opcode;
   logic [5:0] funct;
   logic       legal;

   assign opcode = ir[OPCODE_HI:OPCODE_LO];
   assign funct  = ir[FUNCT_HI:FUNCT_LO];
   assign rs     = ir[RS_HI:RS_LO];
   assign rt     = ir[RT_HI:RT_LO];
   assign rd     = ir[RD_HI:RD_LO];

   always_comb begin
      alu_op = ALU_ADD;
      legal  = 1'b0;
      if (opcode == OPCODE_RTYPE) begin
         case (funct)
            FUNCT_ADD: begin alu_op = ALU_ADD; legal = 1'b1; end
            FUNCT_SUB: begin alu_op = ALU_SUB; legal = 1'b1; end
            FUNCT_MUL: begin alu_op = ALU_MUL; legal = 1'b1; end
            default:   begin alu_op = ALU_ADD; legal = 1'b0; end
         endcase
      end
      is_end     = (ir == '0);
      is_illegal = !is_end && !legal;
   end

endmodule

// File: rtl/mips_fetch_control.sv
// Fetch/decode/execute/writeback sequencer between instruction ROM and the ALU stage.
// All outputs come straight from registers; enable_fsm is the state register itself.
module mips_fetch_control
   import mips_pkg::*;
#(
   parameter int ADDR_W   = 5,
   parameter int DATA_W   = 32,
   parameter int PROG_LEN = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [DATA_W-1:0] rom_data,
   input  logic              op_ready,
   output logic [ADDR_W-1:0] rom_address,
   output logic [2:0]        enable_fsm,
   output logic              op_valid,
   output logic [1:0]        alu_op,
   output logic [4:0]        rs,
   output logic [4:0]        rt,
   output logic [4:0]        rd,
   output logic              reg_write,
   output logic              halt,
   output logic              illegal
);

   localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(PROG_LEN - 1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [DATA_W-1:0] ir_q, ir_d;
   logic              op_valid_q, op_valid_d;
   logic [1:0]        alu_op_q, alu_op_d;
   logic [4:0]        rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
   logic              reg_write_q, reg_write_d;
   logic              halt_q, halt_d;
   logic              illegal_q, illegal_d;

   logic [4:0]        dec_rs, dec_rt, dec_rd;
   logic [1:0]        dec_alu_op;
   logic              dec_is_end, dec_is_illegal;

   mips_instr_decode #(.DATA_W(DATA_W)) u_decode (
      .ir         (ir_q),
      .rs         (dec_rs),
      .rt         (dec_rt),
      .rd         (dec_rd),
      .alu_op     (dec_alu_op),
      .is_end     (dec_is_end),
      .is_illegal (dec_is_illegal)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         pc_q        <= '0;
         ir_q        <= '0;
         op_valid_q  <= 1'b0;
         alu_op_q    <= ALU_ADD;
         rs_q        <= '0;
         rt_q        <= '0;
         rd_q        <= '0;
         reg_write_q <= 1'b0;
         halt_q      <= 1'b0;
         illegal_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         ir_q        <= ir_d;
         op_valid_q  <= op_valid_d;
         alu_op_q    <= alu_op_d;
         rs_q        <= rs_d;
         rt_q        <= rt_d;
         rd_q        <= rd_d;
         reg_write_q <= reg_write_d;
         halt_q      <= halt_d;
         illegal_q   <= illegal_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      ir_d        = ir_q;
      op_valid_d  = op_valid_q;
      alu_op_d    = alu_op_q;
      rs_d        = rs_q;
      rt_d        = rt_q;
      rd_d        = rd_q;
      reg_write_d = 1'b0;
      halt_d      = halt_q;
      illegal_d   = illegal_q;
      case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_FETCH;
         end
         ST_FETCH: begin
            // ROM output settled on the falling edge of this cycle.
            ir_d    = rom_data;
            state_d = ST_DECODE;
         end
         ST_DECODE: begin
            rs_d = dec_rs;
            rt_d = dec_rt;
            rd_d = dec_rd;
            if (dec_is_end) begin
               halt_d    = 1'b1;
               illegal_d = 1'b0;
               state_d   = ST_HALT;
            end else if (dec_is_illegal) begin
               halt_d    = 1'b1;
               illegal_d = 1'b1;
               state_d   = ST_HALT;
            end else begin
               alu_op_d   = dec_alu_op;
               op_valid_d = 1'b1;
               state_d    = ST_EXECUTE;
            end
         end
         ST_EXECUTE: begin
            if (op_valid_q && op_ready) begin
               op_valid_d  = 1'b0;
               reg_write_d = 1'b1;
               state_d     = ST_WRITEBACK;
            end
         end
         ST_WRITEBACK: begin
            // The last slot halts in place rather than wrapping the PC.
            if (pc_q == LAST_PC) begin
               halt_d  = 1'b1;
               state_d = ST_HALT;
            end else begin
               pc_d    = pc_q + ADDR_W'(1);
               state_d = ST_FETCH;
            end
         end
         ST_HALT: begin
            if (start) begin
               pc_d      = '0;
               halt_d    = 1'b0;
               illegal_d = 1'b0;
               state_d   = ST_FETCH;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign rom_address = pc_q;
   assign enable_fsm  = state_q;
   assign op_valid    = op_valid_q;
   assign alu_op      = alu_op_q;
   assign rs          = rs_q;
   assign rt          = rt_q;
   assign rd          = rd_q;
   assign reg_write   = reg_write_q;
   assign halt        = halt_q;
   assign illegal     = illegal_q;

endmodule

// File: tb/tb_mips_fetch_control.sv
// Directed bench for mips_fetch_control: behavioural ROM on the falling edge,
// one task per scenario, hand-computed expectations.
module tb_mips_fetch_control;

   localparam logic [31:0] W_ADD = 32'h00220020;
   localparam logic [31:0] W_SUB = 32'h00220022;
   localparam logic [31:0] W_MUL = 32'h00220026;
   localparam logic [31:0] W_BAD = 32'h00220021;

   logic        clock;
   logic        reset, start, op_ready;
   logic [31:0] rom_data;
   logic [4:0]  rom_address;
   logic [2:0]  enable_fsm;
   logic        op_valid, reg_write, halt, illegal;
   logic [1:0]  alu_op;
   logic [4:0]  rs, rt, rd;

   logic        reset4, start4, op_ready4;
   logic [31:0] rom_data4;
   logic [4:0]  rom_address4;
   logic [2:0]  enable_fsm4;
   logic        op_valid4, reg_write4, halt4, illegal4;
   logic [1:0]  alu_op4;
   logic [4:0]  rs4, rt4, rd4;

   logic [31:0] rom  [32];
   logic [31:0] rom4 [32];

   int checks = 0;
   int errors = 0;

   mips_fetch_control #(.ADDR_W(5), .DATA_W(32), .PROG_LEN(32)) u_dut (
      .clock(clock), .reset(reset), .start(start), .rom_data(rom_data), .op_ready(op_ready),
      .rom_address(rom_address), .enable_fsm(enable_fsm), .op_valid(op_valid), .alu_op(alu_op),
      .rs(rs), .rt(rt), .rd(rd), .reg_write(reg_write), .halt(halt), .illegal(illegal)
   );

   mips_fetch_control #(.ADDR_W(5), .DATA_W(32), .PROG_LEN(4)) u_dut4 (
      .clock(clock), .reset(reset4), .start(start4), .rom_data(rom_data4), .op_ready(op_ready4),
      .rom_address(rom_address4), .enable_fsm(enable_fsm4), .op_valid(op_valid4), .alu_op(alu_op4),
      .rs(rs4), .rt(rt4), .rd(rd4), .reg_write(reg_write4), .halt(halt4), .illegal(illegal4)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(negedge clock) begin
      if (enable_fsm == 3'b000) rom_data <= rom[rom_address];
      if (enable_fsm4 == 3'b000) rom_data4 <= rom4[rom_address4];
   end

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic load_rom(input bit bad1);
      for (int i = 0; i < 32; i++) rom[i] = 32'h0;
      rom[0] = W_ADD;
      rom[1] = bad1 ? W_BAD : W_SUB;
      rom[2] = W_MUL;
   endtask

   task automatic do_reset;
      reset = 1'b1;
      start = 1'b0;
      #2;
      reset = 1'b0;
      tick();
   endtask

   task automatic test_reset;
      #12;
      checks++; if (enable_fsm !== 3'b111) begin errors++; $display("FAIL reset_phase got %b want 111", enable_fsm); end
      checks++; if (rom_address !== 5'd0) begin errors++; $display("FAIL reset_pc got %0d want 0", rom_address); end
      checks++; if ({op_valid, reg_write, halt, illegal} !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b want 0000", {op_valid, reg_write, halt, illegal}); end
      checks++; if ({alu_op, rs, rt, rd} !== 17'd0) begin errors++; $display("FAIL reset_fields got %h want 0", {alu_op, rs, rt, rd}); end
      reset = 1'b0;
      tick();
      checks++; if (enable_fsm !== 3'b111) begin errors++; $display("FAIL idle_hold got %b want 111", enable_fsm); end
   endtask

   task automatic test_program;
      int n;
      int cyc_at [8];
      logic [1:0] ops [8];
      load_rom(1'b0);
      op_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++; if (enable_fsm !== 3'b000 || rom_address !== 5'd0) begin errors++; $display("FAIL first_fetch got phase %b pc %0d want 000 pc 0", enable_fsm, rom_address); end
      n = 0;
      for (int c = 1; c < 40 && !halt; c++) begin
         tick();
         if (reg_write && n < 8) begin
            ops[n] = alu_op;
            cyc_at[n] = c;
            checks++; if (rs !== 5'd1 || rt !== 5'd2 || rd !== 5'd0) begin errors++; $display("FAIL prog_fields got rs %0d rt %0d rd %0d want 1 2 0", rs, rt, rd); end
            n++;
         end
      end
      checks++; if (n !== 3) begin errors++; $display("FAIL prog_wb_count got %0d want 3", n); end
      if (n >= 3) begin
         checks++; if (ops[0] !== 2'b00 || ops[1] !== 2'b01 || ops[2] !== 2'b10) begin errors++; $display("FAIL prog_ops got %b %b %b want 00 01 10", ops[0], ops[1], ops[2]); end
         checks++; if (cyc_at[1] - cyc_at[0] !== 4 || cyc_at[2] - cyc_at[1] !== 4) begin errors++; $display("FAIL prog_spacing got %0d %0d want 4 4", cyc_at[1] - cyc_at[0], cyc_at[2] - cyc_at[1]); end
      end
      checks++; if (halt !== 1'b1 || illegal !== 1'b0 || enable_fsm !== 3'b100) begin errors++; $display("FAIL prog_halt got halt %b illegal %b phase %b want 1 0 100", halt, illegal, enable_fsm); end
      checks++; if (rom_address !== 5'd3) begin errors++; $display("FAIL prog_pc got %0d want 3", rom_address); end
   endtask

   task automatic test_stall;
      do_reset();
      load_rom(1'b0);
      op_ready = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c < 10 && !op_valid; c++) tick();
      for (int k = 0; k < 5; k++) begin
         checks++; if (op_valid !== 1'b1 || enable_fsm !== 3'b010) begin errors++; $display("FAIL stall_valid cyc %0d got valid %b phase %b want 1 010", k, op_valid, enable_fsm); end
         checks++; if ({alu_op, rs, rt, rd} !== {2'b00, 5'd1, 5'd2, 5'd0}) begin errors++; $display("FAIL stall_hold cyc %0d got %h want %h", k, {alu_op, rs, rt, rd}, {2'b00, 5'd1, 5'd2, 5'd0}); end
         tick();
      end
      checks++; if (enable_fsm !== 3'b010 || reg_write !== 1'b0) begin errors++; $display("FAIL stall_no_wb got phase %b wr %b want 010 0", enable_fsm, reg_write); end
      op_ready = 1'b1;
      tick();
      checks++; if (enable_fsm !== 3'b011 || reg_write !== 1'b1 || op_valid !== 1'b0) begin errors++; $display("FAIL stall_release got phase %b wr %b valid %b want 011 1 0", enable_fsm, reg_write, op_valid); end
      for (int c = 0; c < 40 && !halt; c++) tick();
      checks++; if (halt !== 1'b1) begin errors++; $display("FAIL stall_finish got halt %b want 1", halt); end
   endtask

   task automatic test_illegal_relaunch;
      int n;
      do_reset();
      load_rom(1'b1);
      op_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      checks++; if (enable_fsm !== 3'b001) begin errors++; $display("FAIL decode_phase got %b want 001", enable_fsm); end
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++; if (enable_fsm !== 3'b010) begin errors++; $display("FAIL start_ignored got %b want 010", enable_fsm); end
      n = 0;
      for (int c = 0; c < 40 && !halt; c++) begin
         tick();
         if (reg_write) n++;
      end
      checks++; if (n !== 1) begin errors++; $display("FAIL illegal_wb_count got %0d want 1", n); end
      checks++; if (halt !== 1'b1 || illegal !== 1'b1 || rom_address !== 5'd1) begin errors++; $display("FAIL illegal_halt got halt %b illegal %b pc %0d want 1 1 1", halt, illegal, rom_address); end
      load_rom(1'b0);
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++; if (enable_fsm !== 3'b000 || rom_address !== 5'd0 || illegal !== 1'b0 || halt !== 1'b0) begin errors++; $display("FAIL relaunch got phase %b pc %0d illegal %b halt %b want 000 0 0 0", enable_fsm, rom_address, illegal, halt); end
      n = 0;
      for (int c = 0; c < 40 && !halt; c++) begin
         tick();
         if (reg_write) n++;
      end
      checks++; if (n !== 3 || illegal !== 1'b0 || rom_address !== 5'd3) begin errors++; $display("FAIL relaunch_run got wb %0d illegal %b pc %0d want 3 0 3", n, illegal, rom_address); end
   endtask

   task automatic test_reset_mid;
      int c;
      do_reset();
      load_rom(1'b0);
      op_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      c = 0;
      while (c < 20 && !(op_valid && rom_address == 5'd1)) begin
         tick();
         c++;
      end
      op_ready = 1'b0;
      checks++; if (op_valid !== 1'b1 || rom_address !== 5'd1) begin errors++; $display("FAIL mid_reach got valid %b pc %0d want 1 1", op_valid, rom_address); end
      #2;
      reset = 1'b1;
      #1;
      checks++; if ({op_valid, halt, reg_write} !== 3'b000 || rom_address !== 5'd0 || enable_fsm !== 3'b111) begin errors++; $display("FAIL mid_reset got valid %b halt %b wr %b pc %0d phase %b want 0 0 0 0 111", op_valid, halt, reg_write, rom_address, enable_fsm); end
      #1;
      reset = 1'b0;
      op_ready = 1'b1;
      tick();
      checks++; if (enable_fsm !== 3'b111) begin errors++; $display("FAIL mid_idle got %b want 111", enable_fsm); end
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++; if (enable_fsm !== 3'b000 || rom_address !== 5'd0) begin errors++; $display("FAIL mid_restart got phase %b pc %0d want 000 0", enable_fsm, rom_address); end
      for (int k = 0; k < 40 && !halt; k++) tick();
   endtask

   task automatic test_prog_len4;
      int n;
      for (int i = 0; i < 32; i++) rom4[i] = (i < 4) ? W_ADD : 32'h0;
      op_ready4 = 1'b1;
      reset4 = 1'b0;
      tick();
      start4 = 1'b1;
      tick();
      start4 = 1'b0;
      n = 0;
      for (int c = 0; c < 60 && !halt4; c++) begin
         tick();
         if (reg_write4) n++;
      end
      for (int c = 0; c < 8; c++) begin
         tick();
         if (reg_write4) n++;
      end
      checks++; if (n !== 4) begin errors++; $display("FAIL len4_wb_count got %0d want 4", n); end
      checks++; if (halt4 !== 1'b1 || enable_fsm4 !== 3'b100 || rom_address4 !== 5'd3) begin errors++; $display("FAIL len4_halt got halt %b phase %b pc %0d want 1 100 3", halt4, enable_fsm4, rom_address4); end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; op_ready = 1'b0;
      reset4 = 1'b1; start4 = 1'b0; op_ready4 = 1'b0;
      for (int i = 0; i < 32; i++) begin rom[i] = 32'h0; rom4[i] = 32'h0; end
      test_reset();
      test_program();
      test_stall();
      test_illegal_relaunch();
      test_reset_mid();
      test_prog_len4();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
